// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch
// requester and a data (load/store) requester. Data normally has priority.
// A small starvation counter lets a waiting fetch win once data has been
// granted STARVE_LIMIT times in a row while the fetch was waiting.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    // fetch side
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    // data side
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_mode,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    // memory side
    output logic        m_req,
    output logic        m_we,
    output logic [2:0]  m_mode,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    // pipeline hold
    output logic        stall
);

    // Word load/store encoding, used for every fetch and as the reset mode.
    localparam logic [2:0] MODE_LW = 3'b010;
    localparam logic [2:0] LIMIT   = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic        m_we_q, m_we_d;
    logic [2:0]  m_mode_q, m_mode_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        grant_i, grant_d;
    logic        if_ack_c, d_ack_c;

    // Arbitration, ack generation and capture of the granted request.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        m_we_d    = m_we_q;
        m_mode_d  = m_mode_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        if_ack_c  = 1'b0;
        d_ack_c   = 1'b0;
        grant_i   = 1'b0;
        grant_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // data wins a tie unless the fetch has waited long enough
                if (d_req && !(if_req && (starve_q == LIMIT))) begin
                    grant_d = 1'b1;
                end else if (if_req) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I: begin
                if (m_ack) begin
                    if_ack_c = 1'b1;
                    if (d_req) begin
                        grant_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BUSY_D: begin
                if (m_ack) begin
                    d_ack_c = 1'b1;
                    if (if_req) begin
                        grant_i = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_d) begin
            state_d   = BUSY_D;
            m_we_d    = d_we;
            m_mode_d  = d_mode;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            // only grants that make a live fetch wait count towards starvation
            if (!if_req) begin
                starve_d = 3'd0;
            end else if (starve_q != LIMIT) begin
                starve_d = starve_q + 3'd1;
            end
        end else if (grant_i) begin
            state_d   = BUSY_I;
            m_we_d    = 1'b0;
            m_mode_d  = MODE_LW;
            m_addr_d  = if_addr;
            m_wdata_d = 32'h0;
            starve_d  = 3'd0;
        end
    end

    // State, starvation counter and the memory request register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= 3'd0;
            m_we_q    <= 1'b0;
            m_mode_q  <= MODE_LW;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            m_we_q    <= m_we_d;
            m_mode_q  <= m_mode_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign m_req    = (state_q != IDLE);
    assign m_we     = m_we_q;
    assign m_mode   = m_mode_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;

    assign if_ack   = if_ack_c;
    assign d_ack    = d_ack_c;
    assign if_rdata = if_ack_c ? m_rdata : 32'h0;
    assign d_rdata  = d_ack_c ? m_rdata : 32'h0;

    assign stall    = (if_req & ~if_ack_c) | (d_req & ~d_ack_c);

endmodule
